// File: rtl/blackice_reset_ctrl_if.sv
// Signal bundle between the BlackIce PLL/reset domain and the reset controller.
// The master side drives the PLL lock and software request; the slave side is the controller.
interface blackice_reset_ctrl_if #(
    parameter int LOSS_COUNT_WIDTH = 8
);
    logic                        pll_locked;
    logic                        soft_reset_req;
    logic                        soft_reset_ack;
    logic                        sys_reset;
    logic                        sys_resetn;
    logic [LOSS_COUNT_WIDTH-1:0] lock_loss_count;
    logic [2:0]                  state;

    modport master (
        output pll_locked,
        output soft_reset_req,
        input  soft_reset_ack,
        input  sys_reset,
        input  sys_resetn,
        input  lock_loss_count,
        input  state
    );

    modport slave (
        input  pll_locked,
        input  soft_reset_req,
        output soft_reset_ack,
        output sys_reset,
        output sys_resetn,
        output lock_loss_count,
        output state
    );
endinterface

// File: rtl/blackice_reset_ctrl.sv
// SoC reset generator behind the iCE40 PLL: qualifies lock, stretches reset, releases it
// synchronously, and handles lock loss and software-requested resets.
module blackice_reset_ctrl #(
    parameter int LOCK_STABLE_CYCLES = 4096,
    parameter int RESET_HOLD_CYCLES  = 64,
    parameter int SYNC_STAGES        = 2,
    parameter int LOSS_COUNT_WIDTH   = 8
) (
    input  logic                 clock_in,
    input  logic                 resetn,
    blackice_reset_ctrl_if.slave bus
);
    localparam int MAX_CYCLES = (LOCK_STABLE_CYCLES > RESET_HOLD_CYCLES) ?
                                LOCK_STABLE_CYCLES : RESET_HOLD_CYCLES;
    localparam int CNT_W = $clog2(MAX_CYCLES + 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(RESET_HOLD_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_RESET     = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_HOLD      = 3'd3,
        ST_RUN       = 3'd4,
        ST_SOFT_HOLD = 3'd5
    } state_t;

    logic [1:0]                  rel_sync;
    logic [SYNC_STAGES-1:0]      lock_sync;
    logic                        locked_sync;
    logic                        req_prev;
    logic                        req_rise;
    state_t                      state_q;
    state_t                      state_d;
    logic [CNT_W-1:0]            cnt_q;
    logic [CNT_W-1:0]            cnt_d;
    logic                        pending_q;
    logic                        pending_d;
    logic                        ack_q;
    logic                        ack_d;
    logic                        sys_reset_q;
    logic                        sys_resetn_q;
    logic [LOSS_COUNT_WIDTH-1:0] loss_q;
    logic [LOSS_COUNT_WIDTH-1:0] loss_d;

    assign locked_sync = lock_sync[SYNC_STAGES-1];
    assign req_rise    = bus.soft_reset_req & ~req_prev;

    // Synchronizers and request edge register
    always_ff @(posedge clock_in or negedge resetn) begin
        if (!resetn) begin
            rel_sync  <= '0;
            lock_sync <= '0;
            req_prev  <= 1'b0;
        end else begin
            rel_sync  <= {rel_sync[0], 1'b1};
            lock_sync <= {lock_sync[SYNC_STAGES-2:0], bus.pll_locked};
            req_prev  <= bus.soft_reset_req;
        end
    end

    // State, shared counter and registered outputs
    always_ff @(posedge clock_in or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ST_RESET;
            cnt_q        <= '0;
            pending_q    <= 1'b0;
            ack_q        <= 1'b0;
            sys_reset_q  <= 1'b1;
            sys_resetn_q <= 1'b0;
            loss_q       <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pending_q    <= pending_d;
            ack_q        <= ack_d;
            sys_reset_q  <= (state_d != ST_RUN);
            sys_resetn_q <= (state_d == ST_RUN);
            loss_q       <= loss_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pending_d = pending_q;
        loss_d    = loss_q;
        ack_d     = 1'b0;
        case (state_q)
            ST_RESET: begin
                if (rel_sync[1]) state_d = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
                if (locked_sync) begin
                    state_d = ST_STABLE;
                    cnt_d   = '0;
                end
            end
            ST_STABLE: begin
                if (!locked_sync) begin
                    state_d = ST_WAIT_LOCK;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = ST_HOLD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_HOLD, ST_SOFT_HOLD: begin
                if (!locked_sync) begin
                    state_d = ST_WAIT_LOCK;
                end else if (cnt_q == HOLD_LAST) begin
                    state_d = ST_RUN;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RUN: begin
                // Lock loss wins over a simultaneous software request
                if (!locked_sync) begin
                    state_d = ST_WAIT_LOCK;
                    if (loss_q != '1) loss_d = loss_q + LOSS_COUNT_WIDTH'(1);
                end else if (req_rise) begin
                    state_d   = ST_SOFT_HOLD;
                    pending_d = 1'b1;
                    cnt_d     = '0;
                end
            end
            default: begin
                state_d = ST_RESET;
            end
        endcase
        // A pending soft request survives lock loss and is acknowledged on the next RUN entry
        if (state_d == ST_RUN && state_q != ST_RUN && pending_q) begin
            ack_d     = 1'b1;
            pending_d = 1'b0;
        end
    end

    assign bus.soft_reset_ack  = ack_q;
    assign bus.sys_reset       = sys_reset_q;
    assign bus.sys_resetn      = sys_resetn_q;
    assign bus.lock_loss_count = loss_q;
    assign bus.state           = state_q;
endmodule

// File: tb/tb_blackice_reset_ctrl.sv
// Bench for blackice_reset_ctrl: directed scenarios plus randomized lock/request/reset traffic,
// compared every cycle against an elapsed-time reference model.
module tb_blackice_reset_ctrl;
    localparam int LSC      = 8;
    localparam int RHC      = 4;
    localparam int SS       = 2;
    localparam int LW       = 2;
    localparam int LOSS_MAX = (1 << LW) - 1;
    localparam int LOCK_LAT = SS + 1 + LSC + RHC;

    localparam int M_RESET  = 0;
    localparam int M_WAIT   = 1;
    localparam int M_STABLE = 2;
    localparam int M_HOLD   = 3;
    localparam int M_RUN    = 4;
    localparam int M_SOFT   = 5;

    logic clock_in = 1'b0;
    logic resetn   = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    blackice_reset_ctrl_if #(.LOSS_COUNT_WIDTH(LW)) bus ();

    blackice_reset_ctrl #(
        .LOCK_STABLE_CYCLES(LSC),
        .RESET_HOLD_CYCLES (RHC),
        .SYNC_STAGES       (SS),
        .LOSS_COUNT_WIDTH  (LW)
    ) dut (
        .clock_in(clock_in),
        .resetn  (resetn),
        .bus     (bus)
    );

    always #5 clock_in = ~clock_in;

    // Reference model: phase + timestamp of phase entry, lock delay line as a queue
    int  m_state;
    int  m_cyc;
    int  m_start;
    int  m_rel;
    int  m_loss;
    bit  m_pend;
    bit  m_ack;
    bit  m_prev_req;
    bit  lq[$];

    int          ack_seen = 0;
    int          rst_seen = 0;
    logic [31:0] visited  = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0d, expected %0d (cycle %0d)", tag, obs, exp, m_cyc);
        end
    endtask

    task automatic model_reset();
        m_state    = M_RESET;
        m_start    = m_cyc;
        m_rel      = 0;
        m_loss     = 0;
        m_pend     = 1'b0;
        m_ack      = 1'b0;
        m_prev_req = 1'b0;
        lq.delete();
        for (int i = 0; i < SS; i++) lq.push_back(1'b0);
    endtask

    task automatic model_edge();
        bit ls;
        bit rise;
        int nxt;
        int el;
        m_cyc++;
        if (!resetn) begin
            model_reset();
            return;
        end
        ls = lq.pop_front();
        lq.push_back(bus.pll_locked);
        rise       = bus.soft_reset_req && !m_prev_req;
        m_prev_req = bus.soft_reset_req;
        el    = m_cyc - m_start;
        m_ack = 1'b0;
        nxt   = m_state;
        case (m_state)
            M_RESET:  if (m_rel >= 2) nxt = M_WAIT;
            M_WAIT:   if (ls) nxt = M_STABLE;
            M_STABLE: if (!ls) nxt = M_WAIT; else if (el == LSC) nxt = M_HOLD;
            M_HOLD:   if (!ls) nxt = M_WAIT; else if (el == RHC) nxt = M_RUN;
            M_SOFT:   if (!ls) nxt = M_WAIT; else if (el == RHC) nxt = M_RUN;
            M_RUN: begin
                if (!ls) begin
                    nxt = M_WAIT;
                    if (m_loss < LOSS_MAX) m_loss++;
                end else if (rise) begin
                    nxt    = M_SOFT;
                    m_pend = 1'b1;
                end
            end
            default: nxt = M_RESET;
        endcase
        if (nxt == M_RUN && m_state != M_RUN && m_pend) begin
            m_ack  = 1'b1;
            m_pend = 1'b0;
        end
        if (nxt != m_state) m_start = m_cyc;
        m_state = nxt;
        m_rel++;
    endtask

    task automatic compare_all();
        check("state", 32'(bus.state), 32'(m_state));
        check("sys_reset", 32'(bus.sys_reset), (m_state != M_RUN) ? 32'd1 : 32'd0);
        check("sys_resetn", 32'(bus.sys_resetn), (m_state == M_RUN) ? 32'd1 : 32'd0);
        check("ack", 32'(bus.soft_reset_ack), 32'(m_ack));
        check("loss_count", 32'(bus.lock_loss_count), 32'(m_loss));
    endtask

    task automatic cycle();
        @(posedge clock_in);
        model_edge();
        #1;
        compare_all();
        if (bus.soft_reset_ack === 1'b1) ack_seen++;
        if (bus.sys_reset === 1'b1) rst_seen++;
        visited = visited | (32'd1 << bus.state);
    endtask

    task automatic edges_to_release(output int n);
        n = 0;
        do begin
            cycle();
            n++;
        end while (bus.sys_reset !== 1'b0 && n < 200);
    endtask

    task automatic async_reset_now();
        #2;
        resetn = 1'b0;
        model_reset();
        #1;
        check("async_state", 32'(bus.state), 32'(M_RESET));
        check("async_sys_reset", 32'(bus.sys_reset), 32'd1);
        check("async_sys_resetn", 32'(bus.sys_resetn), 32'd0);
        check("async_loss", 32'(bus.lock_loss_count), 32'd0);
        check("async_ack", 32'(bus.soft_reset_ack), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        m_cyc = 0;
        bus.pll_locked     = 1'b1;
        bus.soft_reset_req = 1'b0;
        resetn             = 1'b0;
        model_reset();

        // Power-up with lock already present
        repeat (5) cycle();
        resetn = 1'b1;
        edges_to_release(n);
        check("powerup_run", 32'(bus.state), 32'(M_RUN));
        check("powerup_path", visited, 32'h1f);
        check("powerup_loss", 32'(bus.lock_loss_count), 32'd0);

        // Lock loss in RUN
        bus.pll_locked = 1'b0;
        cycle();
        cycle();
        check("loss_edge2_run", 32'(bus.sys_reset), 32'd0);
        cycle();
        check("loss_edge3_reset", 32'(bus.sys_reset), 32'd1);
        check("loss_edge3_state", 32'(bus.state), 32'(M_WAIT));
        check("loss_count_1", 32'(bus.lock_loss_count), 32'd1);
        repeat (3) cycle();

        // Unstable lock: 5 high, 1 low, then high
        rst_seen = 0;
        bus.pll_locked = 1'b1;
        repeat (5) cycle();
        bus.pll_locked = 1'b0;
        cycle();
        bus.pll_locked = 1'b1;
        edges_to_release(n);
        check("relock_latency", 32'(n), 32'(LOCK_LAT));
        check("unstable_reset_held", 32'(rst_seen), 32'(6 + LOCK_LAT - 1));
        check("unstable_loss", 32'(bus.lock_loss_count), 32'd1);

        // Soft reset held high, then a second request
        for (int r = 0; r < 2; r++) begin
            ack_seen = 0;
            rst_seen = 0;
            bus.soft_reset_req = 1'b1;
            repeat (10) cycle();
            check("soft_reset_width", 32'(rst_seen), 32'(RHC));
            check("soft_ack_once", 32'(ack_seen), 32'd1);
            bus.soft_reset_req = 1'b0;
            repeat (2) cycle();
        end

        // Lock loss during SOFT_HOLD
        bus.soft_reset_req = 1'b1;
        cycle();
        check("soft_hold_entry", 32'(bus.state), 32'(M_SOFT));
        bus.pll_locked     = 1'b0;
        bus.soft_reset_req = 1'b0;
        repeat (3) cycle();
        check("soft_loss_state", 32'(bus.state), 32'(M_WAIT));
        check("soft_loss_count", 32'(bus.lock_loss_count), 32'd1);
        repeat (2) cycle();
        ack_seen = 0;
        bus.pll_locked = 1'b1;
        edges_to_release(n);
        check("soft_requal_latency", 32'(n), 32'(LOCK_LAT));
        check("soft_requal_ack", 32'(ack_seen), 32'd1);

        // Repeated losses saturate the counter
        for (int i = 0; i < 4; i++) begin
            bus.pll_locked = 1'b0;
            repeat (4) cycle();
            bus.pll_locked = 1'b1;
            edges_to_release(n);
        end
        check("loss_saturate", 32'(bus.lock_loss_count), 32'(LOSS_MAX));

        // Asynchronous reset in RUN, then in HOLD
        async_reset_now();
        repeat (2) cycle();
        resetn = 1'b1;
        n = 0;
        do begin
            cycle();
            n++;
        end while (bus.state !== 3'(M_HOLD) && n < 100);
        check("reach_hold", 32'(bus.state), 32'(M_HOLD));
        async_reset_now();
        cycle();
        resetn = 1'b1;

        // Randomized traffic
        for (int k = 0; k < 4000; k++) begin
            cycle();
            if (!resetn) begin
                if ($urandom_range(0, 2) == 0) resetn = 1'b1;
            end else if ($urandom_range(0, 599) == 0) begin
                async_reset_now();
            end
            if (bus.pll_locked) begin
                if ($urandom_range(0, 59) == 0) bus.pll_locked = 1'b0;
            end else if ($urandom_range(0, 3) == 0) begin
                bus.pll_locked = 1'b1;
            end
            if ($urandom_range(0, 7) == 0) bus.soft_reset_req = ~bus.soft_reset_req;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/blackice_reset_ctrl.md
Name: blackice_reset_ctrl

Overview:
- Sits directly downstream of the iCE40 PLL wrapper on BlackIce.
- Runs on the PLL output clock and consumes the PLL lock flag.
- Generates the SoC system reset: asserted until lock has been stable for a qualification window, then held for a minimum reset width, then released synchronously.
- Reasserts reset on lock loss, supports a software-requested reset with acknowledge, and counts lock-loss events for debug.

Parameters:
LOCK_STABLE_CYCLES, 4096, consecutive synchronized-lock cycles required before reset hold starts (>=1)
RESET_HOLD_CYCLES, 64, cycles sys_reset stays asserted after lock qualification or soft request (>=1)
SYNC_STAGES, 2, flops in the pll_locked synchronizer (>=2)
LOSS_COUNT_WIDTH, 8, width of lock_loss_count

Ports:
clock_in  input  1  PLL output clock
resetn  input  1  asynchronous active-low reset (board button / power-on)
pll_locked  input  1  PLL LOCK, asynchronous to clock_in
soft_reset_req  input  1  software reset request, level, synchronous
soft_reset_ack  output  1  one-cycle pulse when a soft reset completes
sys_reset  output  1  active-high system reset, registered
sys_resetn  output  1  registered inverse of sys_reset
lock_loss_count  output  LOSS_COUNT_WIDTH  saturating count of lock losses while in RUN
state  output  3  FSM state: RESET=0, WAIT_LOCK=1, STABLE=2, HOLD=3, RUN=4, SOFT_HOLD=5

Behaviour:
- resetn low: all registers clear asynchronously.
  - state=RESET, sys_reset=1, sys_resetn=0, soft_reset_ack=0, lock_loss_count=0.
  - Synchronizer and counters cleared, pending flag and request edge register cleared.
- resetn release: passes through a 2-flop release synchronizer. RESET→WAIT_LOCK on the first edge after the synchronized release is high.
- Lock synchronization: pll_locked passes through SYNC_STAGES flops; locked_sync is the last stage. All FSM decisions use locked_sync only.
- Single down-counter/up-counter shared by STABLE, HOLD and SOFT_HOLD. Width = clog2(max(LOCK_STABLE_CYCLES, RESET_HOLD_CYCLES)+1).
- WAIT_LOCK: on edge with locked_sync=1 → STABLE, counter←0.
- STABLE:
  - locked_sync=0 → WAIT_LOCK.
  - Otherwise counter+1. At counter==LOCK_STABLE_CYCLES-1 → HOLD, counter←0. STABLE therefore lasts exactly LOCK_STABLE_CYCLES cycles.
- HOLD:
  - locked_sync=0 → WAIT_LOCK; no count increment.
  - Otherwise after RESET_HOLD_CYCLES cycles → RUN.
- RUN:
  - locked_sync=0 → WAIT_LOCK; lock_loss_count+1, saturating at all-ones.
  - Else a rising edge of soft_reset_req (req=1, previous-cycle req=0) → SOFT_HOLD, pending←1, counter←0.
  - Lock loss has priority over a simultaneous soft request; the request is dropped.
- SOFT_HOLD:
  - Lasts RESET_HOLD_CYCLES cycles, then → RUN.
  - locked_sync=0 → WAIT_LOCK; pending stays set, no count increment.
- sys_reset is registered and equals 1 in every state except RUN; it updates on the same edge the state changes. sys_resetn = ~sys_reset at all times.
- soft_reset_ack is registered: 1 for exactly one cycle on the edge entering RUN with pending=1; pending clears on that edge. An ack is never produced without a prior accepted request.
- soft_reset_req held high through SOFT_HOLD and into RUN does not retrigger. It must go low, then high again.
- Soft requests are ignored outside RUN, except that the edge register keeps tracking.
- Latency:
  - pll_locked rise to sys_reset fall = SYNC_STAGES+1+LOCK_STABLE_CYCLES+RESET_HOLD_CYCLES edges, counting the first sampling edge as 1.
  - pll_locked fall in RUN to sys_reset rise = SYNC_STAGES+1 edges.
- pll_locked glitch shorter than one clock: may or may not be captured. If captured, it is treated as a full loss (restart qualification).

Test Plan:
(Benches use LOCK_STABLE_CYCLES=8, RESET_HOLD_CYCLES=4, SYNC_STAGES=2, LOSS_COUNT_WIDTH=2.)
- Power-up:
  - Stimulus: resetn low 5 cycles, then release; pll_locked high from the start.
  - Required: state passes RESET→WAIT_LOCK→STABLE→HOLD→RUN. sys_reset falls exactly 15 edges after the first edge sampling locked high. sys_resetn is always the complement. lock_loss_count=0.
- Unstable lock:
  - Stimulus: pll_locked high 5 cycles, low 1 cycle, then high.
  - Required: STABLE→WAIT_LOCK, counter restarts, sys_reset held continuously high. RUN is reached 15 edges after the final rise. lock_loss_count=0.
- Lock loss in RUN:
  - Stimulus: in RUN, drop pll_locked.
  - Required: sys_reset=1 at the 3rd edge, state=WAIT_LOCK, lock_loss_count=1.
  - Stimulus: repeat the loss 4 times.
  - Required: count saturates at 3.
- Soft reset:
  - Stimulus: in RUN, hold soft_reset_req high 10 cycles.
  - Required: sys_reset=1 for exactly 4 cycles. soft_reset_ack pulses once for 1 cycle on re-entry to RUN. No second reset while req stays high.
  - Stimulus: req low then high.
  - Required: a second cycle occurs.
- Lock loss during SOFT_HOLD:
  - Stimulus: drop pll_locked during SOFT_HOLD, later restore it.
  - Required: WAIT_LOCK, lock_loss_count unchanged. After full requalification (15 edges), RUN is entered together with a single soft_reset_ack pulse.
- Async reset mid-operation:
  - Stimulus: assert resetn in HOLD and in RUN, asynchronously.
  - Required: sys_reset=1 and lock_loss_count=0 immediately, without waiting for a clock edge; state=RESET.
